// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode, operand bypass/forwarding, hazard stall and ID/EX register
// Optional macro FWD_EN enables ID/EX and EX/MEM forwarding; without it the stage stalls on in-flight writers.
module decode_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  output logic              id_stall,
  input  logic              flush,
  output logic [2:0]        rf_src1,
  output logic [2:0]        rf_src2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              exm_regwrite,
  input  logic              exm_memread,
  input  logic [2:0]        exm_dest,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              wb_write,
  input  logic [2:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [3:0]        ex_op,
  output logic [2:0]        ex_rd,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_fwd_a,
  output logic              ex_fwd_b,
  output logic              illegal,
  output logic              halted
);

  logic [3:0]        op;
  logic [2:0]        rd;
  logic [2:0]        rs1;
  logic [2:0]        rs2;
  logic [DATA_W-1:0] imm_ext;
  logic              use1;
  logic              use2;

  assign op      = if_instr[15:12];
  assign rd      = if_instr[11:9];
  assign rs1     = if_instr[8:6];
  assign rs2     = if_instr[5:3];
  assign imm_ext = DATA_W'(if_instr[7:0]);

  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hA: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      4'h6, 4'h8, 4'h9: use1 = 1'b1;
      default: ;
    endcase
  end

  // ADDI reads its own destination as the first operand
  assign rf_src1 = (op == 4'h8) ? rd : rs1;
  assign rf_src2 = rs2;

  logic idex1, idex2, exm1, exm2, wb1, wb2;
  assign idex1 = ex_valid && ex_regwrite && (ex_rd == rf_src1);
  assign idex2 = ex_valid && ex_regwrite && (ex_rd == rf_src2);
  assign exm1  = exm_regwrite && (exm_dest == rf_src1);
  assign exm2  = exm_regwrite && (exm_dest == rf_src2);
  assign wb1   = wb_write && (wb_dest == rf_src1);
  assign wb2   = wb_write && (wb_dest == rf_src2);

  logic [DATA_W-1:0] opnd1, opnd2;
  logic              haz1, haz2, fwd1, fwd2;

`ifdef FWD_EN
  assign opnd1 = (exm1 && !exm_memread) ? exm_data : (wb1 ? wb_data : rf_rdata1);
  assign opnd2 = (exm2 && !exm_memread) ? exm_data : (wb2 ? wb_data : rf_rdata2);
  assign haz1  = (idex1 && ex_memread) || (exm1 && exm_memread);
  assign haz2  = (idex2 && ex_memread) || (exm2 && exm_memread);
  assign fwd1  = idex1 && !ex_memread;
  assign fwd2  = idex2 && !ex_memread;
`else
  logic unused_exm;
  assign unused_exm = ^{exm_data, exm_memread};
  assign opnd1 = wb1 ? wb_data : rf_rdata1;
  assign opnd2 = wb2 ? wb_data : rf_rdata2;
  assign haz1  = idex1 || exm1;
  assign haz2  = idex2 || exm2;
  assign fwd1  = 1'b0;
  assign fwd2  = 1'b0;
`endif

  logic hazard, accept, issue;
  assign hazard   = (use1 && haz1) || (use2 && haz2);
  assign id_stall = halted || (if_valid && !flush && hazard);
  assign accept   = if_valid && !flush && !halted && !hazard;
  // HALT and opcodes C-F are accepted but leave a bubble behind
  assign issue    = accept && (op <= 4'hA);

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_op       <= 4'd0;
      ex_rd       <= 3'd0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_fwd_a    <= 1'b0;
      ex_fwd_b    <= 1'b0;
      illegal     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      ex_valid    <= issue;
      ex_op       <= issue ? op : 4'd0;
      ex_rd       <= issue ? rd : 3'd0;
      ex_a        <= (issue && use1) ? opnd1 : '0;
      ex_b        <= !issue ? '0 :
                     use2 ? opnd2 :
                     ((op == 4'h7) || (op == 4'h8)) ? imm_ext : '0;
      ex_regwrite <= issue && (op >= 4'h1) && (op <= 4'h9);
      ex_memread  <= issue && (op == 4'h9);
      ex_memwrite <= issue && (op == 4'hA);
      ex_fwd_a    <= issue && use1 && fwd1;
      ex_fwd_b    <= issue && use2 && fwd2;
      illegal     <= accept && (op >= 4'hC);
      if (accept && (op == 4'hB))
        halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized self-checking bench for decode_stage against a behavioural model
module tb_decode_stage;
  localparam int DW = 8;
`ifdef FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_valid = 1'b0;
  logic [15:0]   if_instr = '0;
  logic          flush = 1'b0;
  logic [DW-1:0] rf_rdata1 = '0, rf_rdata2 = '0;
  logic          exm_regwrite = 1'b0, exm_memread = 1'b0;
  logic [2:0]    exm_dest = '0;
  logic [DW-1:0] exm_data = '0;
  logic          wb_write = 1'b0;
  logic [2:0]    wb_dest = '0;
  logic [DW-1:0] wb_data = '0;

  logic          id_stall;
  logic [2:0]    rf_src1, rf_src2;
  logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_fwd_a, ex_fwd_b;
  logic [3:0]    ex_op;
  logic [2:0]    ex_rd;
  logic [DW-1:0] ex_a, ex_b;
  logic          illegal, halted;

  decode_stage #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
    .id_stall(id_stall), .flush(flush), .rf_src1(rf_src1), .rf_src2(rf_src2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .exm_regwrite(exm_regwrite), .exm_memread(exm_memread), .exm_dest(exm_dest),
    .exm_data(exm_data), .wb_write(wb_write), .wb_dest(wb_dest), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          valid;
    logic [3:0]    op;
    logic [2:0]    rd;
    logic [DW-1:0] a, b;
    logic          regwrite, memread, memwrite, fwd_a, fwd_b, illegal;
  } st_t;

  st_t        m, m_next;
  logic       m_halted, m_halted_next;
  bit         m_ok = 1'b0;
  logic       exp_stall;
  logic [2:0] exp_s1, exp_s2;

  // What ID/EX must hold after the next edge, given the present inputs and the model's ID/EX
  function automatic void predict();
    logic [3:0]    op;
    logic [2:0]    f_rd, f_rs1, f_rs2;
    logic [7:0]    imm;
    logic [2:0]    src [2];
    bit            used [2];
    logic [DW-1:0] val [2];
    bit            fw [2];
    bit            hazard, take;
    op = if_instr[15:12];
    f_rd = if_instr[11:9];
    f_rs1 = if_instr[8:6];
    f_rs2 = if_instr[5:3];
    imm = if_instr[7:0];
    src[0] = (op == 4'h8) ? f_rd : f_rs1;
    src[1] = f_rs2;
    used[0] = (op >= 4'h1 && op <= 4'h6) || op == 4'h8 || op == 4'h9 || op == 4'hA;
    used[1] = (op >= 4'h1 && op <= 4'h5) || op == 4'hA;
    hazard = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bit in_ex, in_mem, in_wb;
      in_ex  = m.valid && m.regwrite && (m.rd == src[i]);
      in_mem = exm_regwrite && (exm_dest == src[i]);
      in_wb  = wb_write && (wb_dest == src[i]);
      val[i] = (i == 0) ? rf_rdata1 : rf_rdata2;
      if (in_wb) val[i] = wb_data;
      fw[i] = 1'b0;
      if (FWD) begin
        if (in_mem && !exm_memread) val[i] = exm_data;
        fw[i] = in_ex && !m.memread;
        if (used[i] && ((in_ex && m.memread) || (in_mem && exm_memread))) hazard = 1'b1;
      end else if (used[i] && (in_ex || in_mem)) begin
        hazard = 1'b1;
      end
    end
    exp_s1 = src[0];
    exp_s2 = src[1];
    exp_stall = m_halted || (if_valid && !flush && hazard);
    take = if_valid && !flush && !m_halted && !hazard;
    m_next = '{default: '0};
    m_halted_next = m_halted;
    if (reset) begin
      m_halted_next = 1'b0;
    end else begin
      m_next.illegal = take && op >= 4'hC;
      if (take && op == 4'hB) m_halted_next = 1'b1;
      if (take && op <= 4'hA) begin
        m_next.valid    = 1'b1;
        m_next.op       = op;
        m_next.rd       = f_rd;
        m_next.a        = used[0] ? val[0] : '0;
        m_next.b        = used[1] ? val[1] : ((op == 4'h7 || op == 4'h8) ? DW'(imm) : '0);
        m_next.regwrite = op >= 4'h1 && op <= 4'h9;
        m_next.memread  = op == 4'h9;
        m_next.memwrite = op == 4'hA;
        m_next.fwd_a    = used[0] && fw[0];
        m_next.fwd_b    = used[1] && fw[1];
      end
    end
  endfunction

  always @(posedge clk) begin
    predict();
    m = m_next;
    m_halted = m_halted_next;
    if (reset) m_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      predict();
      chk("ex_valid", ex_valid, m.valid);
      chk("ex_op", ex_op, m.op);
      chk("ex_rd", ex_rd, m.rd);
      if (!m.fwd_a) chk("ex_a", ex_a, m.a);
      if (!m.fwd_b) chk("ex_b", ex_b, m.b);
      chk("ex_regwrite", ex_regwrite, m.regwrite);
      chk("ex_memread", ex_memread, m.memread);
      chk("ex_memwrite", ex_memwrite, m.memwrite);
      chk("ex_fwd_a", ex_fwd_a, m.fwd_a);
      chk("ex_fwd_b", ex_fwd_b, m.fwd_b);
      chk("illegal", illegal, m.illegal);
      chk("halted", halted, m_halted);
      chk("id_stall", id_stall, exp_stall);
      chk("rf_src1", rf_src1, exp_s1);
      chk("rf_src2", rf_src2, exp_s2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_env();
    exm_regwrite = 1'b0; exm_memread = 1'b0; exm_dest = '0; exm_data = '0;
    wb_write = 1'b0; wb_dest = '0; wb_data = '0;
  endtask

  initial begin
    logic [3:0] rop;
    int pick;
    tick();
    tick();
    chk("rst ex_valid", ex_valid, 0);
    chk("rst ex_b", ex_b, 0);
    chk("rst illegal", illegal, 0);
    chk("rst halted", halted, 0);
    reset = 1'b0;

    // LDI r1,0x05
    if_valid = 1'b1; if_instr = 16'h7205;
    tick();
    chk("ldi valid", ex_valid, 1);
    chk("ldi op", ex_op, 7);
    chk("ldi rd", ex_rd, 1);
    chk("ldi a", ex_a, 0);
    chk("ldi b", ex_b, 8'h05);
    chk("ldi regwrite", ex_regwrite, 1);

    // ADD r2,r1,r1 right behind the LDI
    if_instr = 16'h1448; rf_rdata1 = 8'h33; rf_rdata2 = 8'h33;
    #1;
`ifdef FWD_EN
    chk("add nostall", id_stall, 0);
    tick();
    chk("add valid", ex_valid, 1);
    chk("add fwd_a", ex_fwd_a, 1);
    chk("add fwd_b", ex_fwd_b, 1);
    chk("add rd", ex_rd, 2);
`else
    chk("add stall1", id_stall, 1);
    tick();
    chk("add bubble1", ex_valid, 0);
    exm_regwrite = 1'b1; exm_dest = 3'd1; exm_data = 8'h05;
    #1;
    chk("add stall2", id_stall, 1);
    tick();
    chk("add bubble2", ex_valid, 0);
    clr_env();
    wb_write = 1'b1; wb_dest = 3'd1; wb_data = 8'h05;
    #1;
    chk("add go", id_stall, 0);
    tick();
    chk("add valid", ex_valid, 1);
    chk("add a wb", ex_a, 8'h05);
    chk("add b wb", ex_b, 8'h05);
`endif
    clr_env();

    // LD r3,[r1] then ADD r4,r3,r2: one bubble
    if_instr = 16'h9640;
    tick();
    chk("ld memread", ex_memread, 1);
    chk("ld rd", ex_rd, 3);
    if_instr = 16'h18D0; rf_rdata2 = 8'h11;
    #1;
    chk("lu stall", id_stall, 1);
    tick();
    chk("lu bubble", ex_valid, 0);
    wb_write = 1'b1; wb_dest = 3'd3; wb_data = 8'h77;
    #1;
    chk("lu release", id_stall, 0);
    tick();
    chk("lu add valid", ex_valid, 1);
    chk("lu add a", ex_a, 8'h77);
    chk("lu add b", ex_b, 8'h11);
    clr_env();

    // MOV r6,r5 with a same-cycle WB of r5
    if_instr = 16'h6D40; rf_rdata1 = 8'h12;
    wb_write = 1'b1; wb_dest = 3'd5; wb_data = 8'hAA;
    tick();
    chk("mov a", ex_a, 8'hAA);
    chk("mov b", ex_b, 0);
    chk("mov op", ex_op, 6);
    clr_env();

    // flush beats a load-use stall
    if_instr = 16'h9640;
    tick();
    if_instr = 16'h18D0; flush = 1'b1;
    #1;
    chk("flush nostall", id_stall, 0);
    tick();
    chk("flush bubble", ex_valid, 0);
    flush = 1'b0;

    // illegal opcode, then HALT
    if_instr = 16'hD000;
    tick();
    chk("illegal pulse", illegal, 1);
    chk("illegal bubble", ex_valid, 0);
    if_instr = 16'h0000;
    tick();
    chk("illegal drop", illegal, 0);
    chk("nop valid", ex_valid, 1);
    if_instr = 16'hB000;
    tick();
    chk("halt set", halted, 1);
    chk("halt bubble", ex_valid, 0);
    if_instr = 16'h7205;
    #1;
    chk("halt stall", id_stall, 1);
    tick();
    chk("halted bubble", ex_valid, 0);
    chk("halt sticky", halted, 1);
    reset = 1'b1;
    tick();
    chk("halt cleared", halted, 0);
    reset = 1'b0; if_valid = 1'b0;
    #1;
    chk("stall cleared", id_stall, 0);

    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = ($urandom_range(0, 59) == 0);
      if_valid = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 9) == 0);
      pick = $urandom_range(0, 99);
      if (pick < 1) rop = 4'hB;
      else if (pick < 5) rop = 4'(12 + $urandom_range(0, 3));
      else rop = 4'($urandom_range(0, 10));
      if_instr = {rop, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                  3'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
      rf_rdata1 = DW'($urandom);
      rf_rdata2 = DW'($urandom);
      exm_regwrite = ($urandom_range(0, 1) == 1);
      exm_memread = exm_regwrite && ($urandom_range(0, 3) == 0);
      exm_dest = 3'($urandom_range(0, 3));
      exm_data = DW'($urandom);
      wb_write = ($urandom_range(0, 1) == 1);
      wb_dest = 3'($urandom_range(0, 3));
      wb_data = DW'($urandom);
    end
    reset = 1'b0; if_valid = 1'b0; flush = 1'b0;
    clr_env();
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
